// File: rtl/uart_rx_io.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_io
// Purpose  : 8N1 UART receive front-end feeding a small show-ahead FIFO.
//            The FIFO head drives the core's IO data line, and a level
//            interrupt is raised while any byte is waiting. The core pops
//            one byte per cycle of ack_i.
// Ports    : clk_i       - system clock, rising edge
//            rst_i       - asynchronous active-high reset
//            rx_i        - serial line, idle high, asynchronous to clk_i
//            ack_i       - pop strobe for the FIFO head
//            irq_o       - high while the FIFO holds at least one byte
//            io_data_o   - FIFO head byte, 8'h00 when empty
//            frame_err_o - 1-cycle pulse, stop bit sampled low, byte dropped
//            overrun_o   - 1-cycle pulse, good byte dropped, FIFO full
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_io #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       ack_i,
    output logic       irq_o,
    output logic [7:0] io_data_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    // Start bit is re-checked at its midpoint; every later bit is sampled
    // one full bit period after that, which lands near each bit centre.
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   c_depth     = (PTR_W + 1)'(FIFO_DEPTH);

    logic             r_rx_meta;
    logic             r_rx_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_frame_err;
    logic             r_overrun;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_stop_sample;
    logic             w_push_req;
    logic             w_push;
    logic             w_pop;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_stop_sample = (r_state == c_stop) && (r_cnt == c_bit_last);
    assign w_push_req    = w_stop_sample && r_rx_s;
    assign w_pop         = ack_i && (r_count != '0);
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push        = w_push_req && ((r_count != c_depth) || ack_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= c_idle;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // Both pulses derive from the single stop-sample cycle with
            // opposite rx_s polarity, so they can never coincide.
            r_frame_err <= w_stop_sample && !r_rx_s;
            r_overrun   <= w_push_req && !w_push;
            case (r_state)
                c_idle: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= c_start;
                    end
                end
                c_start: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= c_data;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= c_idle;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_data: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_stop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_stop: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_state <= c_idle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the output mux hides it whenever count is 0.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    assign irq_o       = (r_count != '0);
    assign io_data_o   = irq_o ? r_mem[r_rd_ptr] : 8'h00;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: doc/uart_rx_io.md
Name: uart_rx_io

Overview:
- Serial receive front-end that sits directly upstream of the core's IO interface.
- Deserialises 8N1 UART frames from an external pin into a small show-ahead FIFO.
- Drives the core's interrupt line (irq_i) and IO data line (io_data_i) from the FIFO head.
- The core pops one byte per ack pulse.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of two >= 2.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- rx_i  input  1  serial line, idle high, asynchronous to clk_i.
- ack_i  input  1  core read strobe; pops the FIFO head, one byte per cycle asserted.
- irq_o  output  1  level interrupt to core irq_i; high while FIFO is non-empty.
- io_data_o  output  8  FIFO head byte to core io_data_i; 8'h00 when empty.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- overrun_o  output  1  one-cycle pulse: valid byte dropped because FIFO full.

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE; baud counter and bit index to 0.
  - Shift register to 0; FIFO pointers and count to 0.
  - Sync flops to 1.
  - Outputs: irq_o=0, io_data_o=0, frame_err_o=0, overrun_o=0.
  - Reset mid-frame abandons the frame; the FIFO is emptied.
- Input sync: rx_i passes through 2 flops (rx_s). All decisions use rx_s, so there is 2 cycles of latency from the pin.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s==0 -> START, counter cleared.
  - START: count to CLKS_PER_BIT/2-1 (integer division), then sample rx_s.
    - rx_s==0 -> DATA, counter cleared, bit index 0.
    - rx_s==1 -> IDLE (glitch reject; no error pulse).
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into the shift register, LSB first.
    - After bit index 7 -> STOP; otherwise increment the index.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - rx_s==1 -> push the byte.
    - rx_s==0 -> frame_err_o pulses for 1 cycle; byte discarded.
    - Either way -> IDLE in the same cycle.
  - IDLE may detect a new start bit on the cycle immediately after STOP exits.
- Push rules:
  - Push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and ack_i pops in the same cycle (simultaneous push+pop when full is legal; count stays FIFO_DEPTH).
  - Otherwise overrun_o pulses for 1 cycle, the byte is dropped, and FIFO contents are unchanged.
- Pop rules:
  - ack_i with count>0 advances the read pointer.
  - ack_i with count==0 is ignored (no underflow, no pointer change).
  - Simultaneous push+pop on a non-full FIFO: count unchanged, both pointers advance.
- FIFO is show-ahead:
  - io_data_o = mem[rd_ptr] when count>0, else 8'h00; registered-memory read, combinational mux.
  - irq_o = (count!=0), combinational from the count register.
- Latency:
  - A pushed byte appears on io_data_o and irq_o is high on the first cycle after the STOP sample edge.
  - After the pop of the last entry, irq_o falls on the next cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits and saturates by construction.
- Error pulses are registered; frame_err_o and overrun_o are never high in the same cycle.

Test Plan:
1. Reset behaviour (CLKS_PER_BIT=4, FIFO_DEPTH=4): assert rst_i for 3 cycles with rx_i=1 -> irq_o=0, io_data_o=8'h00, no pulses. Then send 8'hA5 -> irq_o rises; io_data_o=8'hA5. Pulse ack_i one cycle -> irq_o=0 next cycle, io_data_o=8'h00.
2. Back-to-back frames 8'h01, 8'h80, 8'hFF, 8'h3C with no idle gap and no ack -> count=4; io_data_o=8'h01. Ack four times -> reads 8'h01, 8'h80, 8'hFF, 8'h3C in order; FIFO empty. Extra ack -> ignored, still empty.
3. Overrun: fill with 4 bytes, send a 5th (8'h55) with no ack -> overrun_o is a 1-cycle pulse and head is still the 1st byte. Repeat with ack_i asserted on the STOP sample cycle -> no overrun, 8'h55 stored as the last entry.
4. Framing: send 8'h5A with stop bit driven 0 -> frame_err_o is a 1-cycle pulse and irq_o stays 0. A following valid 8'h12 is received correctly.
5. Glitch: drive rx_i low for 1 cycle, then high -> FSM returns to IDLE from START, no push, no pulse. Then a valid frame 8'hC3 is received.
6. Reset mid-operation: assert rst_i during DATA bit 4 with 2 bytes queued -> all outputs 0 immediately (async). After release with rx_i high, no spurious byte or error pulse.
